// File: rtl/i2c_pkg.sv
// Shared types and helpers for the I2C polling scheduler.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_START,
    ST_ADRS,
    ST_RECV,
    ST_DONE
  } state_t;

  localparam logic READ_BIT = 1'b1;
  localparam int unsigned ADRS_W = 7;
  localparam int unsigned LEN_W  = 3;

  // Slot index width; a single slot still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Receive length limited to 1..rx_max.
  function automatic logic [LEN_W-1:0] clamp_rx_len(input logic [LEN_W-1:0] len,
                                                    input int unsigned rx_max);
    if (len == '0) return LEN_W'(1);
    if (32'(len) > rx_max) return LEN_W'(rx_max);
    return len;
  endfunction

endpackage

// File: rtl/i2c_rr_arbiter.sv
// Combinational round-robin search for the next enabled slot after 'last'.
module i2c_rr_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned pDevNum = 3
) (
  input  logic [pDevNum-1:0]              mask,
  input  logic [idx_width(pDevNum)-1:0]   last,
  output logic [idx_width(pDevNum)-1:0]   next,
  output logic                            valid
);

  localparam int unsigned IDX_W = idx_width(pDevNum);

  int unsigned cand;

  // Walk last+1 .. last+pDevNum (mod pDevNum); first enabled slot wins.
  always_comb begin
    next  = '0;
    valid = 1'b0;
    cand  = 0;
    for (int unsigned i = 1; i <= pDevNum; i++) begin
      cand = (32'(last) + i) % pDevNum;
      if (!valid && mask[IDX_W'(cand)]) begin
        valid = 1'b1;
        next  = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/i2c_poll_scheduler.sv
// Round-robin I2C read poller: issues one read per enabled slot, separated
// by an idle gap, and commits received bytes per slot with a watchdog.
module i2c_poll_scheduler
  import i2c_pkg::*;
#(
  parameter int unsigned pDevNum  = 3,
  parameter int unsigned pRxMax   = 2,
  parameter int unsigned pPollGap = 1000,
  parameter int unsigned pTimeout = 65535
) (
  input  logic                        iSysClk,
  input  logic                        iSysRst,
  input  logic [pDevNum-1:0]          iDevEn,
  input  logic [pDevNum*7-1:0]        iDevAdrs,
  input  logic [pDevNum*3-1:0]        iDevRxLen,
  input  logic                        iErrClr,
  output logic [pDevNum*pRxMax*8-1:0] oRxData,
  output logic [pDevNum-1:0]          oRxVd,
  output logic [pDevNum-1:0]          oNackErr,
  output logic                        oI2CStart,
  output logic [7:0]                  oI2CSend,
  output logic [7:0]                  oI2CBufLen,
  output logic                        oTriState,
  input  logic                        iI2CByteVd,
  input  logic [7:0]                  iSdaByte,
  input  logic                        iI2CAck,
  input  logic                        iI2CBufVd
);

  localparam int unsigned IDX_W = idx_width(pDevNum);
  localparam int unsigned BUF_W = pRxMax * 8;
  localparam int unsigned GAP_W = $clog2(pPollGap + 1);
  localparam int unsigned WD_W  = $clog2(pTimeout + 1);

  state_t             state_q, state_d;
  logic [GAP_W-1:0]   gap_q;
  logic [WD_W-1:0]    wd_q;
  logic [IDX_W-1:0]   last_q, slot_q;
  logic [LEN_W-1:0]   len_q, cnt_q;
  logic [BUF_W-1:0]   buf_q;
  logic [pDevNum-1:0] slot_oh;

  logic [IDX_W-1:0]   arb_next;
  logic               arb_valid;
  logic [LEN_W-1:0]   sel_len;
  logic               gap_done, active, timeout;
  logic               load, clr, shift, nack_set, commit;

  i2c_rr_arbiter #(.pDevNum(pDevNum)) u_arb (
    .mask  (iDevEn),
    .last  (last_q),
    .next  (arb_next),
    .valid (arb_valid)
  );

  assign sel_len  = clamp_rx_len(iDevRxLen[32'(arb_next)*3 +: 3], pRxMax);
  assign slot_oh  = pDevNum'(1) << slot_q;
  assign gap_done = (gap_q == GAP_W'(pPollGap - 1));
  assign active   = (state_q == ST_START) || (state_q == ST_ADRS) ||
                    (state_q == ST_RECV)  || (state_q == ST_DONE);
  assign timeout  = active && (wd_q == WD_W'(pTimeout - 1));

  always_ff @(posedge iSysClk or posedge iSysRst) begin
    if (iSysRst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state and per-cycle datapath strobes; the watchdog overrides all.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    clr      = 1'b0;
    shift    = 1'b0;
    nack_set = 1'b0;
    commit   = 1'b0;
    case (state_q)
      ST_IDLE:   if (gap_done) state_d = ST_SELECT;
      ST_SELECT: begin
        if (arb_valid) begin
          load    = 1'b1;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        clr     = 1'b1;
        state_d = ST_ADRS;
      end
      ST_ADRS: begin
        if (iI2CByteVd) begin
          if (iI2CAck) begin
            state_d = ST_RECV;
          end else begin
            nack_set = 1'b1;
            state_d  = ST_DONE;
          end
        end
      end
      ST_RECV: begin
        if (iI2CByteVd) begin
          shift = 1'b1;
          if ((cnt_q + LEN_W'(1)) == len_q) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (iI2CBufVd) begin
          commit  = (cnt_q == len_q);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (timeout) begin
      state_d  = ST_IDLE;
      nack_set = 1'b1;
      commit   = 1'b0;
      shift    = 1'b0;
    end
  end

  always_ff @(posedge iSysClk or posedge iSysRst) begin
    if (iSysRst) begin
      gap_q      <= '0;
      wd_q       <= '0;
      last_q     <= IDX_W'(pDevNum - 1);
      slot_q     <= '0;
      len_q      <= LEN_W'(1);
      cnt_q      <= '0;
      buf_q      <= '0;
      oRxData    <= '0;
      oRxVd      <= '0;
      oNackErr   <= '0;
      oI2CStart  <= 1'b0;
      oTriState  <= 1'b0;
      oI2CSend   <= '0;
      oI2CBufLen <= 8'd2;
    end else begin
      gap_q     <= (state_q == ST_IDLE && !gap_done) ? gap_q + GAP_W'(1) : '0;
      wd_q      <= (active && !timeout) ? wd_q + WD_W'(1) : '0;
      oI2CStart <= (state_d == ST_START);
      oTriState <= (state_d == ST_RECV);
      if (load) begin
        slot_q     <= arb_next;
        last_q     <= arb_next;
        len_q      <= sel_len;
        oI2CSend   <= {iDevAdrs[32'(arb_next)*7 +: 7], READ_BIT};
        oI2CBufLen <= 8'(sel_len) + 8'd1;
      end
      if (clr) begin
        buf_q <= '0;
        cnt_q <= '0;
      end
      // First byte received drifts up to the most significant position.
      if (shift) begin
        buf_q <= BUF_W'({buf_q, iSdaByte});
        cnt_q <= cnt_q + LEN_W'(1);
      end
      oRxVd <= commit ? slot_oh : '0;
      if (commit) oRxData[32'(slot_q)*BUF_W +: BUF_W] <= buf_q;
      oNackErr <= (iErrClr ? '0 : oNackErr) | (nack_set ? slot_oh : '0);
    end
  end

endmodule

// File: tb/tb_i2c_poll_scheduler.sv
// Directed bench for i2c_poll_scheduler with a small I2C master stand-in.
module tb_i2c_poll_scheduler;

  localparam int unsigned DEV   = 3;
  localparam int unsigned RXMAX = 2;
  localparam int unsigned GAP   = 8;
  localparam int unsigned TMO   = 100;

  logic                     iSysClk = 1'b0;
  logic                     iSysRst;
  logic [DEV-1:0]           iDevEn;
  logic [DEV*7-1:0]         iDevAdrs;
  logic [DEV*3-1:0]         iDevRxLen;
  logic                     iErrClr;
  logic [DEV*RXMAX*8-1:0]   oRxData;
  logic [DEV-1:0]           oRxVd;
  logic [DEV-1:0]           oNackErr;
  logic                     oI2CStart;
  logic [7:0]               oI2CSend;
  logic [7:0]               oI2CBufLen;
  logic                     oTriState;
  logic                     iI2CByteVd;
  logic [7:0]               iSdaByte;
  logic                     iI2CAck;
  logic                     iI2CBufVd;

  int checks = 0;
  int errors = 0;

  always #5 iSysClk = ~iSysClk;

  i2c_poll_scheduler #(
    .pDevNum(DEV), .pRxMax(RXMAX), .pPollGap(GAP), .pTimeout(TMO)
  ) dut (
    .iSysClk(iSysClk), .iSysRst(iSysRst), .iDevEn(iDevEn), .iDevAdrs(iDevAdrs),
    .iDevRxLen(iDevRxLen), .iErrClr(iErrClr), .oRxData(oRxData), .oRxVd(oRxVd),
    .oNackErr(oNackErr), .oI2CStart(oI2CStart), .oI2CSend(oI2CSend),
    .oI2CBufLen(oI2CBufLen), .oTriState(oTriState), .iI2CByteVd(iI2CByteVd),
    .iSdaByte(iSdaByte), .iI2CAck(iI2CAck), .iI2CBufVd(iI2CBufVd)
  );

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge iSysClk);
      if (oI2CStart) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_byte(input logic [7:0] b, input logic ack);
    iSdaByte   = b;
    iI2CAck    = ack;
    iI2CByteVd = 1'b1;
    @(negedge iSysClk);
    iI2CByteVd = 1'b0;
  endtask

  task automatic pulse_bufvd();
    iI2CBufVd = 1'b1;
    @(negedge iSysClk);
    iI2CBufVd = 1'b0;
  endtask

  // One full read: address byte, data bytes (if ACKed), then STOP.
  task automatic run_xact(input logic ack, input logic [7:0] b0, input logic [7:0] b1,
                          input int nbytes, output logic [7:0] send,
                          output logic [7:0] blen, output bit seen);
    wait_start(seen);
    send = oI2CSend;
    blen = oI2CBufLen;
    if (!seen) return;
    @(negedge iSysClk);
    pulse_byte(8'h00, ack);
    if (ack) begin
      if (nbytes > 0) pulse_byte(b0, 1'b0);
      if (nbytes > 1) pulse_byte(b1, 1'b0);
    end
    pulse_bufvd();
  endtask

  task automatic test_reset();
    iSysRst = 1'b1; iDevEn = '0; iDevAdrs = '0; iDevRxLen = '0; iErrClr = 1'b0;
    iI2CByteVd = 1'b0; iSdaByte = '0; iI2CAck = 1'b0; iI2CBufVd = 1'b0;
    repeat (2) @(negedge iSysClk);
    checks++; if (oRxData !== '0) begin errors++; $display("FAIL reset_rxdata got %h exp 0", oRxData); end
    checks++; if (oRxVd !== 3'b000) begin errors++; $display("FAIL reset_rxvd got %b exp 000", oRxVd); end
    checks++; if (oNackErr !== 3'b000) begin errors++; $display("FAIL reset_nack got %b exp 000", oNackErr); end
    checks++; if (oI2CStart !== 1'b0) begin errors++; $display("FAIL reset_start got %b exp 0", oI2CStart); end
    checks++; if (oTriState !== 1'b0) begin errors++; $display("FAIL reset_tri got %b exp 0", oTriState); end
    checks++; if (oI2CSend !== 8'h00) begin errors++; $display("FAIL reset_send got %h exp 00", oI2CSend); end
    checks++; if (oI2CBufLen !== 8'd2) begin errors++; $display("FAIL reset_buflen got %0d exp 2", oI2CBufLen); end
    iSysRst = 1'b0;
  endtask

  task automatic test_receive();
    logic [7:0] send, blen;
    bit seen;
    iDevEn = 3'b111;
    iDevAdrs = {7'h04, 7'h03, 7'h02};
    iDevRxLen = {3'd1, 3'd1, 3'd2};
    run_xact(1'b1, 8'hA5, 8'h3C, 2, send, blen, seen);
    checks++; if (!seen) begin errors++; $display("FAIL rx_start got none exp start"); end
    checks++; if (send !== 8'h05) begin errors++; $display("FAIL rr_send0 got %h exp 05", send); end
    checks++; if (blen !== 8'd3) begin errors++; $display("FAIL rx_buflen got %0d exp 3", blen); end
    checks++; if (oRxData[15:0] !== 16'hA53C) begin errors++; $display("FAIL rx_data0 got %h exp a53c", oRxData[15:0]); end
    checks++; if (oRxData[47:16] !== 32'h0) begin errors++; $display("FAIL rx_data_other got %h exp 0", oRxData[47:16]); end
    checks++; if (oRxVd !== 3'b001) begin errors++; $display("FAIL rx_vd_pulse got %b exp 001", oRxVd); end
    @(negedge iSysClk);
    checks++; if (oRxVd !== 3'b000) begin errors++; $display("FAIL rx_vd_width got %b exp 000", oRxVd); end
  endtask

  task automatic test_round_robin();
    logic [7:0] send, blen;
    bit seen;
    run_xact(1'b1, 8'h11, 8'h00, 1, send, blen, seen);
    checks++; if (send !== 8'h07 || !seen) begin errors++; $display("FAIL rr_send1 got %h exp 07", send); end
    checks++; if (oRxData[31:16] !== 16'h0011) begin errors++; $display("FAIL rr_data1 got %h exp 0011", oRxData[31:16]); end
    run_xact(1'b1, 8'h22, 8'h00, 1, send, blen, seen);
    checks++; if (send !== 8'h09 || !seen) begin errors++; $display("FAIL rr_send2 got %h exp 09", send); end
    checks++; if (oRxData[47:32] !== 16'h0022) begin errors++; $display("FAIL rr_data2 got %h exp 0022", oRxData[47:32]); end
    run_xact(1'b1, 8'h5A, 8'hC3, 2, send, blen, seen);
    checks++; if (send !== 8'h05 || !seen) begin errors++; $display("FAIL rr_send3 got %h exp 05", send); end
    checks++; if (oRxData[15:0] !== 16'h5AC3) begin errors++; $display("FAIL rr_data0 got %h exp 5ac3", oRxData[15:0]); end
  endtask

  task automatic test_nack();
    logic [7:0] send, blen;
    bit seen;
    run_xact(1'b0, 8'h00, 8'h00, 0, send, blen, seen);
    checks++; if (send !== 8'h07 || !seen) begin errors++; $display("FAIL nack_send got %h exp 07", send); end
    checks++; if (oNackErr !== 3'b010) begin errors++; $display("FAIL nack_flag got %b exp 010", oNackErr); end
    checks++; if (oRxVd !== 3'b000) begin errors++; $display("FAIL nack_rxvd got %b exp 000", oRxVd); end
    checks++; if (oRxData[31:16] !== 16'h0011) begin errors++; $display("FAIL nack_keep got %h exp 0011", oRxData[31:16]); end
    iErrClr = 1'b1;
    @(negedge iSysClk);
    iErrClr = 1'b0;
    checks++; if (oNackErr !== 3'b000) begin errors++; $display("FAIL nack_clr got %b exp 000", oNackErr); end
  endtask

  task automatic test_rxlen_clamp();
    logic [7:0] send, blen;
    bit seen;
    iDevRxLen = {3'd0, 3'd1, 3'd7};
    run_xact(1'b1, 8'h77, 8'h00, 1, send, blen, seen);
    checks++; if (send !== 8'h09 || !seen) begin errors++; $display("FAIL clamp_send2 got %h exp 09", send); end
    checks++; if (blen !== 8'd2) begin errors++; $display("FAIL clamp_len0 got %0d exp 2", blen); end
    checks++; if (oRxData[47:32] !== 16'h0077) begin errors++; $display("FAIL clamp_data2 got %h exp 0077", oRxData[47:32]); end
    checks++; if (oRxVd !== 3'b100) begin errors++; $display("FAIL clamp_rxvd2 got %b exp 100", oRxVd); end
    run_xact(1'b1, 8'hBE, 8'hEF, 2, send, blen, seen);
    checks++; if (send !== 8'h05 || !seen) begin errors++; $display("FAIL clamp_send0 got %h exp 05", send); end
    checks++; if (blen !== 8'd3) begin errors++; $display("FAIL clamp_len7 got %0d exp 3", blen); end
    checks++; if (oRxData[15:0] !== 16'hBEEF) begin errors++; $display("FAIL clamp_data0 got %h exp beef", oRxData[15:0]); end
  endtask

  task automatic test_disabled();
    int starts = 0;
    iDevEn = 3'b000;
    for (int i = 0; i < 5 * GAP; i++) begin
      @(negedge iSysClk);
      if (oI2CStart) starts++;
    end
    checks++; if (starts != 0) begin errors++; $display("FAIL disabled_starts got %0d exp 0", starts); end
  endtask

  task automatic test_timeout();
    bit seen;
    bit vd_seen = 1'b0;
    int elapsed = 0;
    iDevEn = 3'b001;
    wait_start(seen);
    checks++; if (!seen) begin errors++; $display("FAIL tmo_start got none exp start"); end
    @(negedge iSysClk); elapsed++;
    pulse_byte(8'h00, 1'b1); elapsed++;
    pulse_byte(8'h12, 1'b0); elapsed++;
    pulse_byte(8'h34, 1'b0); elapsed++;
    checks++; if (oTriState !== 1'b0) begin errors++; $display("FAIL tmo_done_tri got %b exp 0", oTriState); end
    while (!oNackErr[0] && elapsed < 300) begin
      @(negedge iSysClk);
      elapsed++;
      if (oRxVd != 3'b000) vd_seen = 1'b1;
    end
    checks++; if (elapsed != TMO) begin errors++; $display("FAIL tmo_cycles got %0d exp %0d", elapsed, TMO); end
    checks++; if (oNackErr !== 3'b001) begin errors++; $display("FAIL tmo_nack got %b exp 001", oNackErr); end
    checks++; if (vd_seen) begin errors++; $display("FAIL tmo_commit got pulse exp none"); end
    checks++; if (oRxData[15:0] !== 16'hBEEF) begin errors++; $display("FAIL tmo_keep got %h exp beef", oRxData[15:0]); end
    @(negedge iSysClk);
    checks++; if (oI2CStart !== 1'b0 || oTriState !== 1'b0) begin
      errors++; $display("FAIL tmo_idle got start=%b tri=%b exp 0 0", oI2CStart, oTriState);
    end
  endtask

  task automatic test_reset_mid_recv();
    bit seen;
    wait_start(seen);
    checks++; if (!seen) begin errors++; $display("FAIL rst_start got none exp start"); end
    @(negedge iSysClk);
    pulse_byte(8'h00, 1'b1);
    pulse_byte(8'h99, 1'b0);
    checks++; if (oTriState !== 1'b1) begin errors++; $display("FAIL rst_recv_tri got %b exp 1", oTriState); end
    #2 iSysRst = 1'b1;
    #1;
    checks++; if (oTriState !== 1'b0) begin errors++; $display("FAIL rst_async_tri got %b exp 0", oTriState); end
    checks++; if (oRxData !== '0) begin errors++; $display("FAIL rst_async_data got %h exp 0", oRxData); end
    checks++; if (oNackErr !== 3'b000) begin errors++; $display("FAIL rst_async_nack got %b exp 000", oNackErr); end
    checks++; if (oI2CSend !== 8'h00 || oI2CBufLen !== 8'd2) begin
      errors++; $display("FAIL rst_async_bus got send=%h len=%0d exp 00 2", oI2CSend, oI2CBufLen);
    end
    @(negedge iSysClk);
    iSysRst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_receive();
    test_round_robin();
    test_nack();
    test_rxlen_clamp();
    test_disabled();
    test_timeout();
    test_reset_mid_recv();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_poll_scheduler.md
I2C_POLL_SCHEDULER -- requirements
Module: i2c_poll_scheduler

Interface
REQ-001 SHALL have parameter pDevNum, default 3, meaning the number of polled I2C slave slots (1..8).
REQ-002 SHALL have parameter pRxMax, default 2, meaning the maximum number of receive bytes per slot (1..4).
REQ-003 SHALL have parameter pPollGap, default 1000, meaning the idle cycles between transactions (>=1).
REQ-004 SHALL have parameter pTimeout, default 65535, meaning the maximum cycles allowed from start to end of a transaction.
REQ-005 SHALL have port iSysClk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-006 SHALL have port iSysRst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port iDevEn, input, pDevNum bits: per-slot poll enable mask.
REQ-008 SHALL have port iDevAdrs, input, pDevNum*7 bits: 7-bit slave address per slot; slot n at [7n+6:7n].
REQ-009 SHALL have port iDevRxLen, input, pDevNum*3 bits: receive byte count per slot.
REQ-010 SHALL have port iErrClr, input, 1 bit: single-cycle pulse that clears oNackErr.
REQ-011 SHALL have port oRxData, output, pDevNum*pRxMax*8 bits: last committed data per slot.
REQ-012 SHALL have port oRxVd, output, pDevNum bits: one-cycle pulse per slot on commit.
REQ-013 SHALL have port oNackErr, output, pDevNum bits: sticky per-slot NACK or timeout flag.
REQ-014 SHALL have port oI2CStart, output, 1 bit: one-cycle transaction request to the I2C master.
REQ-015 SHALL have port oI2CSend, output, 8 bits: address byte {adrs, 1'b1}, meaning read.
REQ-016 SHALL have port oI2CBufLen, output, 8 bits: transaction length in bytes, 1 + effective rx length.
REQ-017 SHALL have port oTriState, output, 1 bit: 0 means the master drives SDA, 1 means SDA is Hi-Z.
REQ-018 SHALL have port iI2CByteVd, input, 1 bit: one-cycle pulse per byte completed.
REQ-019 SHALL have port iSdaByte, input, 8 bits: received byte, valid with iI2CByteVd.
REQ-020 SHALL have port iI2CAck, input, 1 bit: slave ACK for the address byte, valid with the first iI2CByteVd.
REQ-021 SHALL have port iI2CBufVd, input, 1 bit: one-cycle pulse at end of transaction (STOP sent).

Function
REQ-022 SHALL implement FSM states IDLE, SELECT, START, ADRS, RECV, DONE.
REQ-023 IDLE SHALL count pPollGap cycles, then go to SELECT.
REQ-024 SELECT SHALL pick the next enabled slot round-robin after the last slot served, searching all pDevNum slots in 1 cycle.
REQ-025 If no slot is enabled, SELECT SHALL return to IDLE and issue no start.
REQ-026 SELECT SHALL latch the slot's address and effective rx length; oI2CSend and oI2CBufLen hold these values until the next SELECT.
REQ-027 Effective rx length SHALL be iDevRxLen clamped to 1..pRxMax: 0 becomes 1, and values above pRxMax become pRxMax.
REQ-028 START SHALL assert oI2CStart for exactly 1 cycle, clear the receive shift buffer, then enter ADRS.
REQ-029 ADRS SHALL hold oTriState=0; on iI2CByteVd with iI2CAck=1 it goes to RECV, and with iI2CAck=0 it sets oNackErr[slot] and goes to DONE without commit.
REQ-030 RECV SHALL hold oTriState=1 and on each iI2CByteVd shift iSdaByte into the buffer LSB side, so the first byte ends up most significant.
REQ-031 After the effective rx length of bytes, RECV SHALL go to DONE; further iI2CByteVd pulses are ignored.
REQ-032 DONE SHALL hold oTriState=0 and wait for iI2CBufVd.
REQ-033 On iI2CBufVd in DONE after a successful receive, the block SHALL write the buffer right-aligned into slot n's oRxData, zero unused upper bytes, pulse oRxVd[n] the next cycle, and go to IDLE.
REQ-034 A watchdog SHALL count cycles in START..DONE; on reaching pTimeout it sets oNackErr[slot], makes no commit, and goes to IDLE.
REQ-035 iErrClr SHALL clear all oNackErr bits; if a set event coincides with iErrClr, the set wins.
REQ-036 iI2CBufVd or iI2CByteVd outside ADRS/RECV/DONE SHALL be ignored.
REQ-037 Changes to iDevEn or iDevAdrs mid-transaction SHALL not affect the current transaction; they take effect at the next SELECT.

Reset
REQ-038 On iSysRst the block SHALL go to IDLE with gap counter 0, round-robin pointer at slot pDevNum-1 so slot 0 is served first, and all of the following at 0: oRxData, oRxVd, oNackErr, oI2CStart, oTriState, oI2CSend, and the watchdog.
REQ-039 On iSysRst, oI2CBufLen SHALL reset to 8'd2.
REQ-040 Reset asserted mid-transaction SHALL abort without commit; oRxData keeps no partial data.

Structure
REQ-041 FSM state encodings, the read bit constant, and clamp helpers SHALL reside in shared package i2c_pkg.
REQ-042 The round-robin next-enabled search SHALL be sub-module i2c_rr_arbiter (pDevNum-bit mask plus last index in, next index and valid out, combinational).

Verification
REQ-043 With pDevNum=3, iDevEn=3'b111 and adrs 0x02/0x03/0x04, the bench SHALL see oI2CSend = 0x05, 0x07, 0x09, then 0x05 again, in that order.
REQ-044 With slot 0 rxlen=2, ACK, and bytes 0xA5 then 0x3C, the bench SHALL see oRxData slot0 = 16'hA53C and oRxVd[0] pulse for 1 cycle after iI2CBufVd.
REQ-045 With iI2CAck=0 on slot 1, the bench SHALL see oNackErr=3'b010, no oRxVd, and old slot-1 data retained; then iErrClr clears it to 0.
REQ-046 With rxlen=0 and then rxlen=7 at pRxMax=2, the bench SHALL see oI2CBufLen=2 and then 3.
REQ-047 With iDevEn=0, the bench SHALL see no oI2CStart over 5*pPollGap cycles.
REQ-048 With no iI2CBufVd, the bench SHALL see the timeout at pTimeout set oNackErr[slot] and the FSM return to IDLE; iSysRst asserted mid-RECV forces all outputs to reset values asynchronously.
